// File: rtl/add8_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational W-bit adder between NREQ requesters.
// One add per two cycles: arbitrate -> CALC (operands on adder) -> DONE (result + ack).
module add8_arbiter #(
    parameter  int NREQ = 3,
    parameter  int W    = 8,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   a_in,
    input  logic [NREQ*W-1:0]   b_in,
    output logic [W-1:0]        add_a,
    output logic [W-1:0]        add_b,
    input  logic [W-1:0]        add_sum,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     ack,
    output logic                res_valid,
    output logic [W-1:0]        res_data,
    output logic [IDW-1:0]      res_id,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  winner_q, winner_d;
    logic [W-1:0]    add_a_q, add_a_d;
    logic [W-1:0]    add_b_q, add_b_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            res_valid_q, res_valid_d;
    logic [W-1:0]    res_data_q, res_data_d;
    logic [IDW-1:0]  res_id_q, res_id_d;

    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] winner_mask;
    logic            found;
    logic [IDW-1:0]  win_idx;

    // The requester just served is masked in DONE so its lingering req is not re-granted at once.
    always_comb begin
        winner_mask           = '0;
        winner_mask[winner_q] = 1'b1;
        elig                  = '0;
        if (state_q == IDLE)
            elig = req;
        else if (state_q == DONE)
            elig = req & ~winner_mask;
    end

    // Search upward from the pointer, wrapping modulo NREQ; first eligible wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= NREQ)
                idx = idx - NREQ;
            if (!found && elig[idx]) begin
                found   = 1'b1;
                win_idx = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        winner_d    = winner_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        gnt_d       = gnt_q;
        ack_d       = '0;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;

        case (state_q)
            IDLE, DONE: begin
                gnt_d = '0;
                if (found) begin
                    state_d        = CALC;
                    winner_d       = win_idx;
                    add_a_d        = a_in[win_idx*W +: W];
                    add_b_d        = b_in[win_idx*W +: W];
                    gnt_d[win_idx] = 1'b1;
                    ptr_d          = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                state_d         = DONE;
                res_data_d      = add_sum;
                res_id_d        = winner_q;
                gnt_d           = '0;
                ack_d[winner_q] = 1'b1;
                res_valid_d     = 1'b1;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            winner_q    <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            gnt_q       <= '0;
            ack_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            winner_q    <= winner_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_add8_arbiter.sv
// Directed-vector bench for add8_arbiter with NREQ=3, W=8; the adder is modelled as a plain
// modulo-256 sum driving add_sum.
module tb_add8_arbiter;

    localparam int NREQ = 3;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [W-1:0]      add_a;
    logic [W-1:0]      add_b;
    logic [W-1:0]      add_sum;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic              res_valid;
    logic [W-1:0]      res_data;
    logic [IDW-1:0]    res_id;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign add_sum = add_a + add_b;

    add8_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .gnt(gnt), .ack(ack),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .busy(busy)
    );

    always @(posedge clk) begin
        #1;
        if (res_valid)
            $display("txn: ack=%b res_id=%0d res_data=0x%02h", ack, res_id, res_data);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; req = '0; a_in = '0; b_in = '0;
        tick(); tick();
        vectors++; if (gnt !== 3'b000) begin miscompares++; $display("FAIL reset_gnt got %b want 000", gnt); end
        vectors++; if (ack !== 3'b000) begin miscompares++; $display("FAIL reset_ack got %b want 000", ack); end
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (add_a !== 8'h00 || add_b !== 8'h00) begin miscompares++; $display("FAIL reset_operands got %h/%h want 00/00", add_a, add_b); end
        vectors++; if (res_data !== 8'h00 || res_id !== 2'd0) begin miscompares++; $display("FAIL reset_result got %h id %0d want 00 id 0", res_data, res_id); end
        reset = 1'b0;
    endtask

    task automatic test_single;
        req = 3'b001; a_in[0*W +: W] = 8'h12; b_in[0*W +: W] = 8'h34;
        tick();
        vectors++; if (gnt !== 3'b001) begin miscompares++; $display("FAIL single_gnt got %b want 001", gnt); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_calc got %b want 1", busy); end
        vectors++; if (add_a !== 8'h12 || add_b !== 8'h34) begin miscompares++; $display("FAIL single_operands got %h/%h want 12/34", add_a, add_b); end
        vectors++; if (ack !== 3'b000) begin miscompares++; $display("FAIL single_ack_early got %b want 000", ack); end
        tick();
        vectors++; if (ack !== 3'b001 || res_valid !== 1'b1) begin miscompares++; $display("FAIL single_ack got %b/%b want 001/1", ack, res_valid); end
        vectors++; if (res_data !== 8'h46 || res_id !== 2'd0) begin miscompares++; $display("FAIL single_result got %h id %0d want 46 id 0", res_data, res_id); end
        vectors++; if (gnt !== 3'b000) begin miscompares++; $display("FAIL single_gnt_done got %b want 000", gnt); end
        req = '0;
        tick();
        vectors++; if (busy !== 1'b0 || ack !== 3'b000 || res_valid !== 1'b0) begin miscompares++; $display("FAIL single_idle got busy %b ack %b rv %b want 0 000 0", busy, ack, res_valid); end
        vectors++; if (res_data !== 8'h46) begin miscompares++; $display("FAIL single_hold got %h want 46", res_data); end
    endtask

    task automatic test_overflow;
        req = 3'b010; a_in[1*W +: W] = 8'hC8; b_in[1*W +: W] = 8'h64;
        tick();
        vectors++; if (gnt !== 3'b010) begin miscompares++; $display("FAIL ovf_gnt got %b want 010", gnt); end
        tick();
        vectors++; if (ack !== 3'b010 || res_data !== 8'h2C || res_id !== 2'd1) begin miscompares++; $display("FAIL ovf_result got ack %b %h id %0d want 010 2c id 1", ack, res_data, res_id); end
        req = '0;
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ovf_idle got busy %b want 0", busy); end
    endtask

    task automatic test_simultaneous;
        logic [NREQ-1:0] exp_gnt [7];
        logic [NREQ-1:0] exp_ack [7];
        logic [W-1:0]    exp_sum [3];
        exp_gnt = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b000};
        exp_ack = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000};
        exp_sum = '{8'h11, 8'h22, 8'h33};
        a_in = {8'h30, 8'h20, 8'h10};
        b_in = {8'h03, 8'h02, 8'h01};
        reset = 1'b1; req = 3'b111;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 7; c++) begin
            tick();
            vectors++; if (gnt !== exp_gnt[c]) begin miscompares++; $display("FAIL simul_gnt c%0d got %b want %b", c + 1, gnt, exp_gnt[c]); end
            vectors++; if (ack !== exp_ack[c] || res_valid !== (exp_ack[c] != 0)) begin miscompares++; $display("FAIL simul_ack c%0d got %b/%b want %b", c + 1, ack, res_valid, exp_ack[c]); end
            for (int i = 0; i < NREQ; i++) begin
                if (exp_ack[c][i]) begin
                    vectors++; if (res_data !== exp_sum[i] || res_id !== IDW'(i)) begin miscompares++; $display("FAIL simul_result c%0d got %h id %0d want %h id %0d", c + 1, res_data, res_id, exp_sum[i], i); end
                end
            end
            req = req & ~ack;
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL simul_idle got busy %b want 0", busy); end
    endtask

    task automatic test_fairness;
        logic [NREQ-1:0] exp_gnt [8];
        logic [NREQ-1:0] exp_ack [8];
        exp_gnt = '{3'b001, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000, 3'b100, 3'b000};
        exp_ack = '{3'b000, 3'b001, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000, 3'b100};
        reset = 1'b1; req = '0;
        tick();
        reset = 1'b0; req = 3'b001;
        for (int c = 0; c < 8; c++) begin
            tick();
            vectors++; if (gnt !== exp_gnt[c]) begin miscompares++; $display("FAIL rr_gnt c%0d got %b want %b", c + 1, gnt, exp_gnt[c]); end
            vectors++; if (ack !== exp_ack[c]) begin miscompares++; $display("FAIL rr_ack c%0d got %b want %b", c + 1, ack, exp_ack[c]); end
            if (c == 0) req = 3'b101;
        end
        req = '0;
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rr_idle got busy %b want 0", busy); end
    endtask

    task automatic test_operand_change;
        req = 3'b001; a_in[0*W +: W] = 8'h05; b_in[0*W +: W] = 8'h01;
        tick();
        vectors++; if (gnt !== 3'b001 || add_a !== 8'h05) begin miscompares++; $display("FAIL opchg_grant got %b a=%h want 001 a=05", gnt, add_a); end
        a_in[0*W +: W] = 8'hFF;
        tick();
        vectors++; if (ack !== 3'b001 || res_data !== 8'h06) begin miscompares++; $display("FAIL opchg_result got ack %b %h want 001 06", ack, res_data); end
        req = '0;
        tick();
    endtask

    task automatic test_reset_mid;
        req = 3'b010; a_in[1*W +: W] = 8'h03; b_in[1*W +: W] = 8'h04;
        tick();
        vectors++; if (gnt !== 3'b010) begin miscompares++; $display("FAIL rstmid_gnt got %b want 010", gnt); end
        reset = 1'b1; req = '0;
        tick();
        vectors++; if (gnt !== 3'b000 || ack !== 3'b000 || res_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_ctrl got gnt %b ack %b rv %b busy %b want all 0", gnt, ack, res_valid, busy); end
        vectors++; if (add_a !== 8'h00 || add_b !== 8'h00 || res_data !== 8'h00 || res_id !== 2'd0) begin miscompares++; $display("FAIL rstmid_data got %h %h %h %0d want 0", add_a, add_b, res_data, res_id); end
        reset = 1'b0;
        tick();
        vectors++; if (ack !== 3'b000 || res_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_noack got %b/%b want 000/0", ack, res_valid); end
        // Pointer back at 0 means requester 1 beats requester 2.
        req = 3'b110; a_in[2*W +: W] = 8'h0A; b_in[2*W +: W] = 8'h0B;
        tick();
        vectors++; if (gnt !== 3'b010) begin miscompares++; $display("FAIL rstmid_ptr got %b want 010", gnt); end
        tick();
        vectors++; if (ack !== 3'b010 || res_data !== 8'h07) begin miscompares++; $display("FAIL rstmid_r1 got ack %b %h want 010 07", ack, res_data); end
        req = 3'b100;
        tick();
        vectors++; if (gnt !== 3'b100) begin miscompares++; $display("FAIL rstmid_g2 got %b want 100", gnt); end
        tick();
        vectors++; if (ack !== 3'b100 || res_id !== 2'd2 || res_data !== 8'h15) begin miscompares++; $display("FAIL rstmid_r2 got ack %b id %0d %h want 100 id 2 15", ack, res_id, res_data); end
        req = '0;
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle got busy %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_simultaneous();
        test_fairness();
        test_operand_change();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
